ex_div_ctrl: RTL and testbench
==============================

Name: ex_div_ctrl

Overview:
- Iterative RV32M divide sequencer for the execute stage; handles DIV, DIVU, REM and REMU.
- Accepts operands already resolved by the execute operand muxes (post-forwarding) and runs a radix-2 restoring division.
- Stalls the pipeline while the operation is in flight, then presents the result for write-back through the normal execute result path.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req  input  1  execute stage holds a divide/remainder instruction; held high until done
- div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- a_in  input  XLEN  dividend (rs1 after forwarding)
- b_in  input  XLEN  divisor (rs2 after forwarding)
- flush  input  1  kill the in-flight operation
- stall  output  1  freeze IF/ID/EX pipeline registers
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  quotient or remainder, registered

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE, busy 0, done 0, result 0, counter 0. stall is forced 0 while rst is high.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - If req && !flush at a clock edge, latch op, |a|, |b| and the sign flags. Signed ops only: neg_q = a[31]^b[31] and neg_r = a[31].
  - Counter loads 0, remainder register loads 0.
  - Next state is CALC, or DONE for a special case.
- Special cases, decided in IDLE, next state DONE with result loaded directly:
  - b == 0: quotient = all ones; remainder = a_in.
  - Signed a == 0x80000000 and b == 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- CALC:
  - Each cycle: shift {rem, quo} left by 1, trial-subtract |b|, set the quotient LSB on no borrow.
  - Runs exactly XLEN cycles (counter 0..31). At counter == XLEN-1, go to SIGN.
- SIGN:
  - Negate the quotient if neg_q; negate the remainder if neg_r (signed ops only).
  - Select quotient or remainder by div_op[1], register it into result, go to DONE.
- DONE:
  - done = 1 for exactly one cycle; next state IDLE.
  - req is ignored in this cycle; it still belongs to the finishing instruction.
- Latency (req first sampled at the end of cycle 0):
  - Normal: CALC in cycles 1-32, SIGN in cycle 33, done in cycle 34.
  - Special case: done in cycle 1.
- stall = req && !done && !rst, combinational. The pipeline advances in the done cycle.
- result holds its value until the next SIGN or special-case load. It is not cleared by IDLE.
- Back-to-back ops: a new instruction may raise req in the cycle after DONE; it is accepted from IDLE normally.
- flush: at the next edge, state goes to IDLE from any state and done is not asserted; result is unchanged.
  - flush in the same cycle as an IDLE req means the req is not accepted.
- rst mid-operation: returns to IDLE, clears result; no done is produced.
- Priority: rst > flush > normal sequencing.
- Operand changes on a_in/b_in after acceptance are ignored; operands are latched.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |a| < |b| (unsigned compare of the magnitudes, not a special case), go directly to SIGN. Quotient = 0, remainder = a; SIGN applies the normal sign rules; done arrives in cycle 2.
- Undefined: all non-special ops take the full 34-cycle path; no magnitude comparator is built.

Test Plan:
- DIV, a=100, b=7, req held: stall high in cycles 0-33; done in cycle 34 with result=14; stall low in cycle 34.
- REM, a=-7 (0xFFFFFFF9), b=2 -> result 0xFFFFFFFF (-1) at cycle 34. DIVU with the same operands -> 0x7FFFFFFC.
- DIVU, b=0, a=0x1234 -> done in cycle 1, result 0xFFFFFFFF. REMU with the same operands -> 0x1234 in cycle 1.
- DIV, a=0x80000000, b=0xFFFFFFFF -> 0x80000000 in cycle 1. REM with the same operands -> 0.
- Pulse flush in cycle 10 of a DIV:
  - cycle 11: IDLE, busy 0, no done, result unchanged.
  - New DIVU 9/3 requested in cycle 12 -> done in cycle 46 with 3.
  - Repeat with rst instead of flush -> result reads 0.
- DIV_EARLY_OUT_EN defined, DIV a=-3, b=10 -> done in cycle 2, result 0. REM with the same operands -> 0xFFFFFFFD. Without the macro, both complete in cycle 34 with the same values.

Source files
------------

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: iterative RV32M divide sequencer (DIV/DIVU/REM/REMU) for EX.
// Radix-2 restoring divider; stalls the pipe until a one-cycle done pulse.
// Ports: clk, rst (sync, active-high), req, div_op[1:0], a_in, b_in, flush
//        -> stall, busy, done, result (registered).
// Optional: define DIV_EARLY_OUT_EN to skip iteration when |a| < |b|.
module ex_div_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state;
  logic             sel_rem;
  logic             neg_q;
  logic             neg_r;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [CNT_W-1:0] cnt;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [XLEN-1:0]  a_abs;
  logic [XLEN-1:0]  b_abs;
  logic             b_zero;
  logic             ovf;
  logic             special;
  logic [XLEN-1:0]  spec_res;
  logic             early;
  logic [XLEN:0]    r_sh;
  logic [XLEN:0]    diff;
  logic [XLEN-1:0]  q_fin;
  logic [XLEN-1:0]  r_fin;

  assign is_signed = ~div_op[0];
  assign a_neg     = is_signed & a_in[XLEN-1];
  assign b_neg     = is_signed & b_in[XLEN-1];
  assign a_abs     = a_neg ? -a_in : a_in;
  assign b_abs     = b_neg ? -b_in : b_in;

  assign b_zero  = (b_in == '0);
  assign ovf     = is_signed & (a_in == MIN_NEG) & (b_in == '1);
  assign special = b_zero | ovf;

  // div-by-zero: q = all ones, r = a; overflow: q = MIN_NEG, r = 0
  always_comb begin
    spec_res = '0;
    if (b_zero)
      spec_res = div_op[1] ? a_in : '1;
    else
      spec_res = div_op[1] ? '0 : MIN_NEG;
  end

`ifdef DIV_EARLY_OUT_EN
  assign early = (a_abs < b_abs);
`else
  assign early = 1'b0;
`endif

  // shift {rem, quo} left by one, then trial-subtract the divisor
  assign r_sh = {rem, quo[XLEN-1]};
  assign diff = r_sh - {1'b0, b_q};

  assign q_fin = neg_q ? -quo : quo;
  assign r_fin = neg_r ? -rem : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sel_rem <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      b_q     <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      result  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            sel_rem <= div_op[1];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            b_q     <= b_abs;
            cnt     <= '0;
            if (special) begin
              quo    <= a_abs;
              rem    <= '0;
              result <= spec_res;
              state  <= S_DONE;
            end else if (early) begin
              quo   <= '0;
              rem   <= a_abs;
              state <= S_SIGN;
            end else begin
              quo   <= a_abs;
              rem   <= '0;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!diff[XLEN]) begin
            rem <= diff[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= r_sh[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN-1))
            state <= S_SIGN;
        end
        S_SIGN: begin
          result <= sel_rem ? r_fin : q_fin;
          state  <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign stall = req & ~done & ~rst;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: directed-vector bench for ex_div_ctrl.
// Checks latency, results, special cases, flush and reset mid-op.
module tb_ex_div_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic [1:0]  div_op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp;
  int n_bad;
  logic [31:0] last_res;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_CYC = 2;
`else
  localparam int EARLY_CYC = 34;
`endif

  ex_div_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .div_op (div_op),
    .a_in   (a_in),
    .b_in   (b_in),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // req raised mid cycle 0, held until done; cycles counted per posedge
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_cyc);
    int   cyc;
    logic got;
    logic stall_ok;
    @(negedge clk);
    div_op = op;
    a_in   = a;
    b_in   = b;
    req    = 1'b1;
    #1;
    stall_ok = stall;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      a_in = ~a;
      b_in = b ^ 32'h5;
      if (done) got = 1'b1;
      else if (!stall) stall_ok = 1'b0;
    end
    check({tag, "/seen"}, 32'(got), 32'd1);
    check({tag, "/cyc"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "/res"}, result, exp_res);
    check({tag, "/stall_done"}, 32'(stall), 32'd0);
    check({tag, "/stall_held"}, 32'(stall_ok), 32'd1);
    req = 1'b0;
    last_res = exp_res;
    @(posedge clk);
    #1;
    check({tag, "/pulse"}, 32'(done), 32'd0);
    check({tag, "/idle"}, 32'(busy), 32'd0);
  endtask

  // start a DIV 100/7, then kill it in cycle 10 with flush or rst
  task automatic kill_op(input string tag, input logic use_rst);
    @(negedge clk);
    div_op = OP_DIV;
    a_in   = 32'd100;
    b_in   = 32'd7;
    req    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    if (use_rst) begin
      rst = 1'b1;
      #1;
      check({tag, "/stall_rst"}, 32'(stall), 32'd0);
    end else begin
      flush = 1'b1;
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    flush = 1'b0;
    req   = 1'b0;
    if (use_rst) last_res = 32'd0;
    check({tag, "/busy"}, 32'(busy), 32'd0);
    check({tag, "/done"}, 32'(done), 32'd0);
    check({tag, "/res"}, result, last_res);
    @(posedge clk);
    #1;
    check({tag, "/done2"}, 32'(done), 32'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    last_res = 32'd0;
    rst      = 1'b1;
    req      = 1'b1;
    flush    = 1'b0;
    div_op   = OP_DIV;
    a_in     = 32'd0;
    b_in     = 32'd0;
    #1;
    check("rst/stall", 32'(stall), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    #1;
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/res", result, 32'd0);
    check("rst/stall_idle", 32'(stall), 32'd0);

    run_op("div100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 34);
    run_op("rem100_7", OP_REM, 32'd100, 32'd7, 32'd2, 34);
    run_op("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34);
    run_op("rem_m100_7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu_m7_2", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);
    run_op("divu_b0", OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_b0", OP_REMU, 32'h1234, 32'd0, 32'h1234, 1);
    run_op("rem_b0_neg", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu_nonovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EARLY_CYC);
    run_op("div_m3_10", OP_DIV, 32'hFFFF_FFFD, 32'd10, 32'd0, EARLY_CYC);
    run_op("rem_m3_10", OP_REM, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, EARLY_CYC);

    kill_op("flush", 1'b0);
    @(posedge clk);
    run_op("after_flush", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    kill_op("rstmid", 1'b1);
    @(posedge clk);
    run_op("after_rst", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    @(negedge clk);
    div_op = OP_DIVU;
    a_in   = 32'd9;
    b_in   = 32'd3;
    req    = 1'b1;
    flush  = 1'b1;
    @(posedge clk);
    #1;
    check("idle_flush/busy", 32'(busy), 32'd0);
    flush = 1'b0;
    req   = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
